// File: rtl/lamp_pattern_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : lamp_pattern_seq                                               |
// | Purpose : WIDTH-lamp flash / walk / alternate sequencer with prescaler,  |
// |           auto-cycle or manual mode selection. Optional macro            |
// |           PINGPONG_EN makes the walking light bounce back.               |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module lamp_pattern_seq #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   auto_cycle,
  input  logic [1:0]             mode_sel,
  output logic [WIDTH-1:0]       lamb,
  output logic [1:0]             mode_out,
  output logic [$clog2(WIDTH):0] step_out,
  output logic                   frame_done
);

  localparam int STEP_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] c_MODE_FLASH = 2'd0;
  localparam logic [1:0] c_MODE_WALK  = 2'd1;
  localparam logic [1:0] c_MODE_ALT   = 2'd2;
  localparam logic [1:0] c_MODE_OFF   = 2'd3;

  localparam logic [DIV_W-1:0] c_PRESC_LAST = DIV_W'(DIV - 1);

`ifdef PINGPONG_EN
  localparam int c_WALK_LEN = 2 * WIDTH - 2;
`else
  localparam int c_WALK_LEN = WIDTH;
`endif
  localparam logic [STEP_W-1:0] c_WALK_LAST = STEP_W'(c_WALK_LEN - 1);

  logic [DIV_W-1:0]  r_presc;
  logic [1:0]        r_mode;
  logic [STEP_W-1:0] r_step;
  logic [WIDTH-1:0]  r_lamb;
  logic              r_frame_done;

  logic              w_tick;
  logic              w_frame_end;
  logic [STEP_W-1:0] w_last_step;
  logic [1:0]        w_mode_auto;
  logic [DIV_W-1:0]  w_presc_nxt;
  logic [1:0]        w_mode_nxt;
  logic [STEP_W-1:0] w_step_nxt;
  logic [WIDTH-1:0]  w_lamb_nxt;

  function automatic logic [WIDTH-1:0] f_pattern(input logic [1:0]        m,
                                                 input logic [STEP_W-1:0] k);
    logic [WIDTH-1:0] p;
    p = '0;
    case (m)
      c_MODE_FLASH: p = (k != '0) ? '1 : '0;
      c_MODE_WALK: begin
        // Outbound steps light from the left; return steps (ping-pong only) from the right.
        for (int i = 0; i < WIDTH; i++) begin
          if (int'(k) < WIDTH) p[i] = (i == WIDTH - 1 - int'(k));
          else                 p[i] = (i == int'(k) - WIDTH + 1);
        end
      end
      c_MODE_ALT:  p = (k == '0) ? {WIDTH/2{2'b01}} : {WIDTH/2{2'b10}};
      default:     p = '0;
    endcase
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_mode       <= c_MODE_FLASH;
      r_step       <= '0;
      r_lamb       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_presc_nxt;
      r_mode       <= w_mode_nxt;
      r_step       <= w_step_nxt;
      r_lamb       <= w_lamb_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  always_comb begin
    w_tick = en && (r_presc == c_PRESC_LAST);

    case (r_mode)
      c_MODE_FLASH: w_last_step = STEP_W'(1);
      c_MODE_WALK:  w_last_step = c_WALK_LAST;
      c_MODE_ALT:   w_last_step = STEP_W'(1);
      default:      w_last_step = '0;
    endcase

    case (r_mode)
      c_MODE_FLASH: w_mode_auto = c_MODE_WALK;
      c_MODE_WALK:  w_mode_auto = c_MODE_ALT;
      default:      w_mode_auto = c_MODE_FLASH;
    endcase

    w_frame_end = w_tick && (r_step == w_last_step);

    w_presc_nxt = r_presc;
    w_mode_nxt  = r_mode;
    w_step_nxt  = r_step;

    if (en) w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;

    // Mode inputs are only looked at on the frame-end tick.
    if (w_frame_end) begin
      w_mode_nxt = auto_cycle ? w_mode_auto : mode_sel;
      w_step_nxt = '0;
    end else if (w_tick) begin
      w_step_nxt = r_step + 1'b1;
    end
  end

  always_comb begin
    w_lamb_nxt = r_lamb;
    if (w_tick) w_lamb_nxt = f_pattern(w_mode_nxt, w_step_nxt);
  end

  assign lamb       = r_lamb;
  assign mode_out   = r_mode;
  assign step_out   = r_step;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire
